// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the PC, drives the synchronous instruction SRAM and applies
// branch/jump redirects resolved in decode.
//
// Redirects that arrive while the stage is stalled are kept in a one-entry
// pending-redirect register, so they are never lost. If several arrive during
// one stall, the newest one replaces the older ones.
//
// Ports:
//   clk             in   1   clock, all state updates on posedge
//   rst             in   1   synchronous reset, active-high
//   stall           in   6   pipeline stall bus; stall[0]=1 freezes IF
//   br_bus          in  33   {br_e, br_addr[31:0]} from decode (combinational)
//   if_to_id_bus    out 33   {ce, pc[31:0]} to decode
//   inst_sram_en    out  1   SRAM read enable
//   inst_sram_wen   out  4   SRAM byte write enables, always 4'b0000
//   inst_sram_addr  out 32   SRAM read address (= pc)
//   inst_sram_wdata out 32   SRAM write data, always 0
//   excp_adel       out  1   fetch address-error flag (only with IF_ADEL_EN)
//
// Optional feature macro: IF_ADEL_EN
//   Adds a registered misaligned-fetch flag (excp_adel). While it is set, the
//   SRAM enable is suppressed, but the flagged PC is still sent to decode.
//
// Handshake: there is no valid/ready pair. An advance happens on every cycle
// where stall[0]==0, and decode latches {ce,pc} on the same edge that the PC
// moves. The SRAM address is presented in cycle N and its data returns in
// cycle N+1.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfbf_fffc,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
`ifdef IF_ADEL_EN
    ,
    output logic        excp_adel
`endif
);

    localparam logic STOP = 1'b1;

    logic        br_e;
    logic [31:0] br_addr;
    logic        advance;

    logic [31:0] pc_r;
    logic        ce_r;
    logic        pend_v;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;

    // Only stall[0] concerns IF; the upper bits belong to later stages.
    logic        unused_stall;
    assign unused_stall = ^stall[5:1];

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign advance = (stall[0] != STOP);

    // A live redirect beats a held one; a held one beats sequential flow.
    always_comb begin
        next_pc = pc_r + PC_STEP;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_v) begin
            next_pc = pend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            ce_r      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 32'b0;
        end else if (advance) begin
            pc_r   <= next_pc;
            ce_r   <= 1'b1;
            // Any held redirect is either consumed now or overridden by a
            // live one, so it is dropped in both cases.
            pend_v <= 1'b0;
        end else if (br_e) begin
            pend_v    <= 1'b1;
            pend_addr <= br_addr;
        end
    end

`ifdef IF_ADEL_EN
    logic adel_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            adel_r <= 1'b0;
        end else if (advance) begin
            adel_r <= (next_pc[1:0] != 2'b00);
        end
    end

    assign excp_adel    = adel_r;
    assign inst_sram_en = ce_r & ~adel_r;
`else
    assign inst_sram_en = ce_r;
`endif

    assign inst_sram_addr  = pc_r;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'b0;
    assign if_to_id_bus    = {ce_r, pc_r};

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit -- directed testbench for if_fetch_unit.
// Inputs change just after the falling edge. Outputs are sampled just before
// the next change, which keeps them away from the rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hbfbf_fffc;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
`ifdef IF_ADEL_EN
    logic        excp_adel;
`endif

    int n_checks;
    int n_fail;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_bus         (br_bus),
        .if_to_id_bus   (if_to_id_bus),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata)
`ifdef IF_ADEL_EN
        ,
        .excp_adel      (excp_adel)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_br(input logic e, input logic [31:0] a);
        br_bus = {e, a};
    endtask

    // Checks that a fetch of addr is running: en high, ce high, address on both
    // the SRAM port and the decode bus.
    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, addr});
        check({tag, ".en"},   {32'b0, inst_sram_en},  33'd1);
        check({tag, ".bus"},  if_to_id_bus,           {1'b1, addr});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        stall    = 6'b0;
        br_bus   = 33'b0;
        @(negedge clk);

        // T1: reset state, then sequential fetch from the boot vector.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1.rst_en",   {32'b0, inst_sram_en}, 33'd0);
            check("t1.rst_bus",  if_to_id_bus,          {1'b0, RESET_PC});
            check("t1.rst_wen",  {29'b0, inst_sram_wen}, 33'd0);
            check("t1.rst_wdat", {1'b0, inst_sram_wdata}, 33'd0);
        end
        rst = 1'b0;
        tick(); expect_fetch("t1.a0", 32'hbfc0_0000);
        tick(); expect_fetch("t1.a1", 32'hbfc0_0004);
        tick(); expect_fetch("t1.a2", 32'hbfc0_0008);
        tick(); expect_fetch("t1.a3", 32'hbfc0_000c);
        tick(); expect_fetch("t1.a4", 32'hbfc0_0010);

        // T2: one-cycle branch pulse.
        set_br(1'b1, 32'hbfc0_0100);
        tick(); expect_fetch("t2.tgt", 32'hbfc0_0100);
        set_br(1'b0, 32'h0);
        tick(); expect_fetch("t2.seq", 32'hbfc0_0104);

        // br_e=0 must ignore br_addr.
        set_br(1'b0, 32'h1234_5678);
        tick(); expect_fetch("t2.noe", 32'hbfc0_0108);
        set_br(1'b0, 32'h0);

        // T3: redirect arriving in stall cycle 2 is held and applied on release.
        set_br(1'b1, 32'hbfc0_0020);
        tick(); expect_fetch("t3.pre", 32'hbfc0_0020);
        set_br(1'b0, 32'h0);
        stall = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) set_br(1'b1, 32'hbfc0_0200);
            else        set_br(1'b0, 32'h0);
            tick(); expect_fetch("t3.hold", 32'hbfc0_0020);
        end
        check("t3.pend_v", {32'b0, dut.pend_v}, 33'd1);
        stall = 6'b0;
        tick(); expect_fetch("t3.rel", 32'hbfc0_0200);
        check("t3.pend_clr", {32'b0, dut.pend_v}, 33'd0);
        tick(); expect_fetch("t3.seq", 32'hbfc0_0204);

        // T4: newest held redirect wins, then a live branch on release
        // overrides it.
        stall = 6'b000001;
        set_br(1'b1, 32'hbfc0_0280);
        tick();
        set_br(1'b1, 32'hbfc0_0300);
        tick(); expect_fetch("t4.hold", 32'hbfc0_0204);
        set_br(1'b0, 32'h0);
        tick();
        check("t4.pend_addr", {1'b0, dut.pend_addr}, {1'b0, 32'hbfc0_0300});
        stall = 6'b0;
        set_br(1'b1, 32'hbfc0_0400);
        tick(); expect_fetch("t4.live", 32'hbfc0_0400);
        check("t4.pend_v", {32'b0, dut.pend_v}, 33'd0);
        set_br(1'b0, 32'h0);
        tick(); expect_fetch("t4.seq", 32'hbfc0_0404);

        // Wrap boundary: the carry is dropped.
        set_br(1'b1, 32'hffff_fffc);
        tick(); expect_fetch("wrap.top", 32'hffff_fffc);
        set_br(1'b0, 32'h0);
        tick(); expect_fetch("wrap.zero", 32'h0000_0000);

        // T5: reset while a redirect is held drops it.
        stall = 6'b000001;
        set_br(1'b1, 32'hbfc0_0500);
        tick();
        check("t5.pend_set", {32'b0, dut.pend_v}, 33'd1);
        set_br(1'b1, 32'hbfc0_0600);
        rst = 1'b1;
        tick();
        check("t5.pend_v", {32'b0, dut.pend_v}, 33'd0);
        check("t5.rst_en", {32'b0, inst_sram_en}, 33'd0);
        check("t5.rst_bus", if_to_id_bus, {1'b0, RESET_PC});
        rst   = 1'b0;
        stall = 6'b0;
        set_br(1'b0, 32'h0);
        tick(); expect_fetch("t5.boot", 32'hbfc0_0000);
        tick(); expect_fetch("t5.seq", 32'hbfc0_0004);

`ifdef IF_ADEL_EN
        // T6: misaligned redirect raises the fetch address error.
        set_br(1'b1, 32'hbfc0_0102);
        tick();
        check("t6.adel",  {32'b0, excp_adel},    33'd1);
        check("t6.en",    {32'b0, inst_sram_en}, 33'd0);
        check("t6.bus",   if_to_id_bus,          {1'b1, 32'hbfc0_0102});
        set_br(1'b1, 32'hbfc0_0200);
        tick();
        check("t6.adel_clr", {32'b0, excp_adel}, 33'd0);
        expect_fetch("t6.ok", 32'hbfc0_0200);
        set_br(1'b0, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
